serial_word_shifter: RTL and testbench

- Upstream feeder for the serial sequence-detector FSMs.
- Accepts parallel words over a valid/ready handshake and serialises each onto the single-bit stream `w` consumed by the detector.
- A programmable divider holds each bit for DIV clocks, with a one-cycle bit strobe.
- Supports pause (enable), zero-gap back-to-back words and an end-of-word pulse.

---
 rtl/serial_word_shifter.sv | 175 +++++++++++++++++
 tb/tb_serial_word_shifter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_shifter.sv
// -----------------------------------------------------------------------------
// serial_word_shifter
//
// Purpose: accepts parallel words over a valid/ready handshake and serialises
// each one onto the single-bit stream `w` that feeds the serial sequence
// detectors. Each bit is held for DIV enabled clocks; `enable` low freezes
// the word in flight.
//
// Ports:
//   clock       in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   data_in     in   [WIDTH] word to serialise, sampled on handshake
//   data_valid  in   producer has a word on data_in
//   data_ready  out  shifter can accept a word this cycle
//   enable      in   1 = advance divider / bit counters, 0 = freeze
//   w           out  serial bit stream (registered)
//   bit_strobe  out  one-cycle pulse in the first cycle of each new bit
//   busy        out  a word is in flight
//   done        out  one-cycle pulse in the last cycle of the last bit
// -----------------------------------------------------------------------------
module serial_word_shifter #(
  parameter int WIDTH      = 8,
  parameter int DIV        = 1,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             enable,
  output logic             w,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [DW-1:0]    r_div;
  logic [BW-1:0]    r_bit;
  logic             r_last_pos;  // counters sit on the final cycle of the last bit
  logic             r_w;
  logic             r_strobe;
  logic             r_busy;

  logic             w_adv;
  logic             w_div_wrap;
  logic             w_final;
  logic             w_ready;
  logic             w_load;
  logic             w_last_nxt;
  logic [DW-1:0]    w_div_nxt;
  logic [BW-1:0]    w_bit_nxt;
  logic [WIDTH-1:0] w_shift_nxt;

  // Bit that goes on the line first for a given shift-register content.
  function automatic logic first_bit(input logic [WIDTH-1:0] word);
    if (MSB_FIRST) begin
      return word[WIDTH-1];
    end else begin
      return word[0];
    end
  endfunction

  // Shift register contents after one bit has been consumed.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] word);
    if (MSB_FIRST) begin
      return {word[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, word[WIDTH-1:1]};
    end
  endfunction

  // Handshake qualification and next-count arithmetic.
  always_comb begin
    w_adv      = (r_state == ST_SHIFT) && enable;
    w_div_wrap = (r_div == DIV_MAX);
    // The final cycle only counts when enable is high in that very cycle,
    // which is why done and data_ready are qualified combinationally.
    w_final    = w_adv && r_last_pos;
    w_ready    = (r_state == ST_IDLE) || w_final;
    w_load     = data_valid && w_ready;
    if (w_div_wrap) begin
      w_div_nxt = '0;
      w_bit_nxt = r_bit + BW'(1);
    end else begin
      w_div_nxt = r_div + DW'(1);
      w_bit_nxt = r_bit;
    end
    w_last_nxt  = (w_div_nxt == DIV_MAX) && (w_bit_nxt == BIT_MAX);
    w_shift_nxt = shift_word(r_shift);
  end

  // Shifter FSM: load on handshake, advance on enabled cycles, return to idle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_div      <= '0;
      r_bit      <= '0;
      r_last_pos <= 1'b0;
      r_w        <= IDLE_LEVEL;
      r_strobe   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_SHIFT: begin
          if (w_load) begin
            // Covers both a fresh start and a zero-gap back-to-back word.
            r_state    <= ST_SHIFT;
            r_shift    <= data_in;
            r_div      <= '0;
            r_bit      <= '0;
            r_last_pos <= 1'b0;  // WIDTH >= 2, so bit 0 is never the last
            r_w        <= first_bit(data_in);
            r_strobe   <= 1'b1;
            r_busy     <= 1'b1;
          end else if (w_final) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_div      <= '0;
            r_bit      <= '0;
            r_last_pos <= 1'b0;
            r_w        <= IDLE_LEVEL;
            r_strobe   <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_adv) begin
            r_div      <= w_div_nxt;
            r_bit      <= w_bit_nxt;
            r_last_pos <= w_last_nxt;
            if (w_div_wrap) begin
              r_shift  <= w_shift_nxt;
              r_w      <= first_bit(w_shift_nxt);
              r_strobe <= 1'b1;
            end else begin
              r_strobe <= 1'b0;
            end
          end else begin
            // Idle with no handshake, or paused mid-word: hold everything.
            r_strobe <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_shift    <= '0;
          r_div      <= '0;
          r_bit      <= '0;
          r_last_pos <= 1'b0;
          r_w        <= IDLE_LEVEL;
          r_strobe   <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready = w_ready;
  assign done       = w_final;
  assign w          = r_w;
  assign bit_strobe = r_strobe;
  assign busy       = r_busy;

endmodule

// File: tb/tb_serial_word_shifter.sv
// -----------------------------------------------------------------------------
// tb_serial_word_shifter
//
// Two shifters share one stimulus stream: dut0 (DIV=1, MSB first) and
// dut1 (DIV=4, LSB first). A reference model tracks, per shifter, the word
// in flight and the number of enabled cycles spent on it; the expected
// outputs for each cycle are queued and a separate monitor compares them.
// -----------------------------------------------------------------------------
module tb_serial_word_shifter;

  localparam int WIDTH = 8;

  logic             clock      = 1'b0;
  logic             resetn     = 1'b0;
  logic [WIDTH-1:0] data_in    = '0;
  logic             data_valid = 1'b0;
  logic             enable     = 1'b1;

  logic [1:0] ready_o;
  logic [1:0] w_o;
  logic [1:0] strobe_o;
  logic [1:0] busy_o;
  logic [1:0] done_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int k;
    bit w;
    bit s;
    bit b;
    bit d;
    bit r;
  } exp_t;

  exp_t sb[$];

  // Reference model state per shifter.
  bit               m_busy   [2];
  logic [WIDTH-1:0] m_word   [2];
  int               m_p      [2];
  bit               m_strobe [2];

  always #5 clock = ~clock;

  serial_word_shifter #(.WIDTH(WIDTH), .DIV(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut0 (
    .clock(clock), .resetn(resetn), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready_o[0]), .enable(enable), .w(w_o[0]), .bit_strobe(strobe_o[0]),
    .busy(busy_o[0]), .done(done_o[0]));

  serial_word_shifter #(.WIDTH(WIDTH), .DIV(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dut1 (
    .clock(clock), .resetn(resetn), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready_o[1]), .enable(enable), .w(w_o[1]), .bit_strobe(strobe_o[1]),
    .busy(busy_o[1]), .done(done_o[1]));

  function automatic int div_of(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  // Bit currently on the line: enabled-cycle position / DIV selects the bit.
  function automatic bit m_bit(int k);
    int idx;
    idx = m_p[k] / div_of(k);
    if (k == 0) return m_word[k][WIDTH-1-idx];
    else        return m_word[k][idx];
  endfunction

  function automatic bit m_done(int k);
    return m_busy[k] && enable && (m_p[k] == WIDTH * div_of(k) - 1);
  endfunction

  function automatic bit m_ready(int k);
    return !m_busy[k] || m_done(k);
  endfunction

  task automatic m_clear(int k);
    m_busy[k]   = 1'b0;
    m_p[k]      = 0;
    m_strobe[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) m_clear(k);
  end

  // Reset empties the model at once, like the hardware.
  always @(negedge resetn) begin
    for (int k = 0; k < 2; k++) m_clear(k);
  end

  // Model update at each edge, then prediction once new inputs are applied.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      bit hs;
      bit fin;
      if (!resetn) begin
        m_clear(k);
      end else begin
        hs  = data_valid && m_ready(k);
        fin = m_done(k);
        if (m_busy[k] && enable && !fin) begin
          m_p[k]++;
          m_strobe[k] = (m_p[k] % div_of(k)) == 0;
        end else if (hs) begin
          m_busy[k]   = 1'b1;
          m_word[k]   = data_in;
          m_p[k]      = 0;
          m_strobe[k] = 1'b1;
        end else if (fin) begin
          m_clear(k);
        end else begin
          m_strobe[k] = 1'b0;
        end
      end
    end
    #2;
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e.k = k;
      e.w = m_busy[k] ? m_bit(k) : 1'b0;
      e.s = m_strobe[k];
      e.b = m_busy[k];
      e.d = m_done(k);
      e.r = m_ready(k);
      sb.push_back(e);
    end
  end

  task automatic chk(string name, int k, logic got, bit expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t got=%b expected=%b", name, k, $time, got, expv);
    end
  endtask

  // Monitor: compare everything the predictor has queued for this cycle.
  always @(negedge clock) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("w",          e.k, w_o[e.k],      e.w);
      chk("bit_strobe", e.k, strobe_o[e.k], e.s);
      chk("busy",       e.k, busy_o[e.k],   e.b);
      chk("done",       e.k, done_o[e.k],   e.d);
      chk("data_ready", e.k, ready_o[e.k],  e.r);
    end
  end

  task automatic drive(bit v, logic [WIDTH-1:0] d, bit en, int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      data_valid = v;
      data_in    = d;
      enable     = en;
    end
  endtask

  initial begin
    // Held in reset for three cycles.
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 2);

    // Single word A5.
    drive(1'b1, 8'hA5, 1'b1, 1);
    drive(1'b0, 8'h00, 1'b1, 40);

    // Back-to-back B0 then 0D, the second offered in the done cycle.
    drive(1'b1, 8'hB0, 1'b1, 1);
    drive(1'b0, 8'h00, 1'b1, 7);
    drive(1'b1, 8'h0D, 1'b1, 1);
    drive(1'b0, 8'h00, 1'b1, 45);

    // Word 01 (exercises the DIV=4, LSB-first shifter).
    drive(1'b1, 8'h01, 1'b1, 1);
    drive(1'b0, 8'h00, 1'b1, 40);

    // Pause for five cycles during bit 3, with an ignored data_valid.
    drive(1'b1, 8'hFF, 1'b1, 1);
    drive(1'b0, 8'h00, 1'b1, 3);
    drive(1'b1, 8'h3C, 1'b0, 5);
    drive(1'b0, 8'h00, 1'b1, 45);

    // Accept while paused in idle.
    drive(1'b1, 8'h5A, 1'b0, 1);
    drive(1'b0, 8'h00, 1'b0, 3);
    drive(1'b0, 8'h00, 1'b1, 40);

    // Reset mid-word, asserted between clock edges.
    drive(1'b1, 8'hFF, 1'b1, 1);
    drive(1'b0, 8'h00, 1'b1, 4);
    @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    chk("rst_now_w",     0, w_o[0],     1'b0);
    chk("rst_now_busy",  0, busy_o[0],  1'b0);
    chk("rst_now_ready", 0, ready_o[0], 1'b1);
    chk("rst_now_done",  0, done_o[0],  1'b0);
    chk("rst_now_strb",  0, strobe_o[0], 1'b0);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    drive(1'b1, 8'h96, 1'b1, 1);
    drive(1'b0, 8'h00, 1'b1, 40);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clock);
      #1;
      data_valid = 1'($urandom_range(0, 1));
      data_in    = WIDTH'($urandom);
      enable     = ($urandom_range(0, 9) != 0);
      resetn     = ($urandom_range(0, 299) != 0);
    end
    @(posedge clock);
    #1 resetn = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 40);

    @(negedge clock);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d entries expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound on the run.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
